// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared state, op encodings and parameter defaults for the unified-memory responder
package mem_if_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;
  localparam int ADDR_W_D = 14;
  localparam int LINE_W_D = 64;
  localparam int LAT_D = 4;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/line_ram.sv
// line_ram: single-port line array with write enable and a registered, read-enabled output
module line_ram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LINE_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [LINE_W-1:0]     wdata,
  output logic [LINE_W-1:0]     rdata
);
  logic [LINE_W-1:0] mem [2**DEPTH_LOG2];
  // array write; contents survive reset
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  // output register only changes on a read, so it holds the last read line
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/unified_mem_responder.sv
// unified_mem_responder: fixed-latency line memory answering cache fill/evict requests
module unified_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int LINE_W = LINE_W_D,
  parameter int DEPTH_LOG2 = 10,
  parameter int LAT = LAT_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              u_re,
  input  logic              u_we,
  input  logic [ADDR_W-1:0] u_addr,
  input  logic [LINE_W-1:0] u_wdata,
  output logic [LINE_W-1:0] u_rdata,
  output logic              u_rdy,
  output logic              busy,
  output logic              err
);
  state_t state, nxt;
  logic [3:0] cnt, cnt_nxt;
  logic op;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic req;
  logic unused_addr_hi;
  assign req = u_re | u_we;
  assign busy = state != IDLE;
  assign unused_addr_hi = ^u_addr[ADDR_W-1:DEPTH_LOG2];
  // next state and latency countdown
  always_comb begin
    nxt = state == IDLE ? (req ? WAIT : IDLE) : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
    cnt_nxt = (state == IDLE && req) ? 4'(LAT - 2) : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  end
  // control registers; u_rdy registered from the RESP entry condition
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      u_rdy <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      u_rdy <= nxt == RESP;
      if (state == IDLE && req) err <= err | (u_re & u_we);
    end
  // request capture only on acceptance; later changes on the bus are ignored
  always_ff @(posedge clk)
    if (state == IDLE && req) begin
      addr_q <= u_addr[DEPTH_LOG2-1:0];
      wdata_q <= u_wdata;
      op <= u_we ? OP_WR : OP_RD;
    end
  line_ram #(.DEPTH_LOG2(DEPTH_LOG2), .LINE_W(LINE_W)) ram (
    .clk(clk),
    .rst(rst),
    .we(state == RESP && op == OP_WR && !rst),
    .re(state == WAIT && cnt == 4'd0 && op == OP_RD && !rst),
    .addr(addr_q),
    .wdata(wdata_q),
    .rdata(u_rdata)
  );
endmodule

// File: tb/tb_unified_mem_responder.sv
// tb_unified_mem_responder: scoreboard bench for the responder at LAT=4 plus LAT=2/15 latency sweep
module tb_unified_mem_responder;
  typedef struct {
    int          due;
    bit          rd;
    logic [63:0] data;
  } sb_t;
  logic clk = 0, rst = 1;
  logic u_re = 0, u_we = 0, u_rdy, busy, err;
  logic [13:0] u_addr = 0;
  logic [63:0] u_wdata = 0, u_rdata;
  logic r2_re = 0, r2_we = 0, r2_rdy, r2_busy, r2_err;
  logic [13:0] r2_addr = 0;
  logic [63:0] r2_wdata = 0, r2_rdata;
  logic f_re = 0, f_we = 0, f_rdy, f_busy, f_err;
  logic [13:0] f_addr = 0;
  logic [63:0] f_wdata = 0, f_rdata;
  int cyc = 0, tests = 0, fails = 0;
  sb_t sbq[$];
  sb_t m;
  logic prev_rdy = 0, prev_r2 = 0, prev_f = 0;
  int lat;
  logic [63:0] rd;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  unified_mem_responder #(.LAT(4)) dut (
    .clk(clk), .rst(rst), .u_re(u_re), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_rdata(u_rdata), .u_rdy(u_rdy), .busy(busy), .err(err));
  unified_mem_responder #(.LAT(2)) dut2 (
    .clk(clk), .rst(rst), .u_re(r2_re), .u_we(r2_we), .u_addr(r2_addr), .u_wdata(r2_wdata),
    .u_rdata(r2_rdata), .u_rdy(r2_rdy), .busy(r2_busy), .err(r2_err));
  unified_mem_responder #(.LAT(15)) dut15 (
    .clk(clk), .rst(rst), .u_re(f_re), .u_we(f_we), .u_addr(f_addr), .u_wdata(f_wdata),
    .u_rdata(f_rdata), .u_rdy(f_rdy), .busy(f_busy), .err(f_err));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // every u_rdy pulse pops the oldest expectation and checks its cycle and read data
  always @(negedge clk) begin
    if (!rst) begin
      if (u_rdy) begin
        if (sbq.size() == 0) check("rdy_unexpected", u_rdy, 0);
        else begin
          m = sbq.pop_front();
          check("rdy_cycle", 64'(cyc), 64'(m.due));
          if (m.rd) check("rdata", u_rdata, m.data);
        end
      end
      if (u_rdy && prev_rdy) check("rdy_back2back", u_rdy, 0);
      if (r2_rdy && prev_r2) check("rdy2_back2back", r2_rdy, 0);
      if (f_rdy && prev_f) check("rdy15_back2back", f_rdy, 0);
    end
    prev_rdy = u_rdy;
    prev_r2 = r2_rdy;
    prev_f = f_rdy;
  end
  task automatic issue(input logic re, input logic we, input logic [13:0] a, input logic [63:0] wd,
                       input logic [63:0] exp);
    sb_t e;
    int st;
    st = u_rdy ? cyc + 1 : cyc;
    u_re = re;
    u_we = we;
    u_addr = a;
    u_wdata = wd;
    e.due = st + 4;
    e.rd = re && !we;
    e.data = exp;
    sbq.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_rdy) return;
    end
    check("rdy_timeout", u_rdy, 1);
  endtask
  task automatic idle();
    u_re = 0;
    u_we = 0;
  endtask
  task automatic drive(input bit sel, input logic re, input logic we, input logic [13:0] a,
                       input logic [63:0] wd);
    if (sel) begin
      f_re = re; f_we = we; f_addr = a; f_wdata = wd;
    end else begin
      r2_re = re; r2_we = we; r2_addr = a; r2_wdata = wd;
    end
  endtask
  task automatic measure(input bit sel, input logic we, input logic [13:0] a, input logic [63:0] wd,
                         input bit tog, output int l, output logic [63:0] r);
    int c0;
    c0 = cyc;
    l = -1;
    r = 'x;
    drive(sel, !we, we, a, wd);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (sel ? f_rdy : r2_rdy) begin
        l = cyc - c0;
        r = sel ? f_rdata : r2_rdata;
        drive(sel, 0, 0, a, wd);
        return;
      end
      if (tog) drive(sel, i[0], !i[0], a ^ 14'(i), {$urandom, $urandom});
    end
    check("lat_timeout", sel ? f_rdy : r2_rdy, 1);
    drive(sel, 0, 0, a, wd);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      check("reset_idle", {u_rdy, busy, err, u_rdata}, 0);
      @(negedge clk);
    end
    issue(0, 1, 14'h0005, 64'h1111_2222_3333_4444, 0);
    idle();
    @(negedge clk);
    issue(1, 0, 14'h0005, 0, 64'h1111_2222_3333_4444);
    idle();
    @(negedge clk);
    issue(0, 1, 14'h0020, 64'hBBBB_0000_BBBB_0020, 0);
    idle();
    @(negedge clk);
    check("rdata_held_after_write", u_rdata, 64'h1111_2222_3333_4444);
    issue(0, 1, 14'h0010, 64'hAAAA_0000_AAAA_0010, 0);
    issue(1, 0, 14'h0020, 0, 64'hBBBB_0000_BBBB_0020);
    idle();
    @(negedge clk);
    issue(1, 0, 14'h0010, 0, 64'hAAAA_0000_AAAA_0010);
    idle();
    @(negedge clk);
    issue(0, 1, 14'h0003, 64'h5555_6666_7777_8888, 0);
    idle();
    @(negedge clk);
    u_we = 1;
    u_addr = 14'h0003;
    u_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    check("busy_in_wait", busy, 1);
    u_we = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_idle", {busy, u_rdy}, 0);
    repeat (8) @(negedge clk);
    check("abort_quiet", busy, 0);
    issue(1, 0, 14'h0003, 0, 64'h5555_6666_7777_8888);
    idle();
    @(negedge clk);
    check("err_clear", err, 0);
    issue(1, 1, 14'h0007, 64'hCCCC_1234_CCCC_5678, 0);
    idle();
    @(negedge clk);
    check("err_set", err, 1);
    issue(1, 0, 14'h0007, 0, 64'hCCCC_1234_CCCC_5678);
    idle();
    @(negedge clk);
    check("err_sticky", err, 1);
    issue(0, 1, 14'h0405, 64'h0F0F_0F0F_A11A_5005, 0);
    idle();
    @(negedge clk);
    issue(1, 0, 14'h0005, 0, 64'h0F0F_0F0F_A11A_5005);
    idle();
    @(negedge clk);
    measure(0, 1, 14'h0001, 64'h2222_0000_0000_0002, 0, lat, rd);
    check("lat2_write", lat, 2);
    @(negedge clk);
    measure(0, 0, 14'h0001, 0, 1, lat, rd);
    check("lat2_read", lat, 2);
    check("lat2_rdata", rd, 64'h2222_0000_0000_0002);
    @(negedge clk);
    measure(1, 1, 14'h0012, 64'hEEEE_1515_EEEE_0012, 1, lat, rd);
    check("lat15_write", lat, 15);
    @(negedge clk);
    measure(1, 0, 14'h0012, 0, 0, lat, rd);
    check("lat15_read", lat, 15);
    check("lat15_rdata", rd, 64'hEEEE_1515_EEEE_0012);
    repeat (6) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
